// File: rtl/pattern_gen.sv
// pattern_gen - synthesizable video timing and grayscale test-image source.
//
// Produces de/hsync/vsync timing plus an 8-bit test image in the stream format
// consumed by the filter blocks, so it can stand in for the HDMI receiver.
// All outputs are registered: the values after an enabled edge describe the
// raster position held before that edge.
//
// Ports:
//   clk        pixel clock, rising edge
//   rst_n      asynchronous active-low reset
//   ce         clock enable; low freezes all state and outputs
//   mode[1:0]  pattern select, taken at the start of each frame
//                0 horizontal ramp, 1 vertical ramp, 2 checkerboard, 3 moving bar
//   out_image  pixel value, 0 outside active video
//   out_de     active video
//   out_hsync  horizontal sync, active-high
//   out_vsync  vertical sync, active-high
//   out_sof    (PATTERN_GEN_SOF_EN only) one-clock pulse with the (0,0) pixel
//
// Optional feature macro: PATTERN_GEN_SOF_EN adds the out_sof port.
module pattern_gen #(
  parameter int H_ACTIVE = 64,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 4,
  parameter int V_ACTIVE = 64,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [1:0] mode,
  output logic [7:0] out_image,
  output logic       out_de,
  output logic       out_hsync,
  output logic       out_vsync
`ifdef PATTERN_GEN_SOF_EN
  ,
  output logic       out_sof
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_BAR     = 2'd3
  } pattern_e;

  logic [11:0] h, v;
  logic [11:0] h_nxt, v_nxt;
  logic [7:0]  frame_cnt, frame_cnt_nxt;
  pattern_e    mode_q, mode_eff;

  logic        at_origin, line_end, frame_end;
  logic        de, hsync, vsync;
  logic [7:0]  pixel;

  always_comb begin
    at_origin = (h == '0) && (v == '0);
    line_end  = (h == H_LAST);
    frame_end = line_end && (v == V_LAST);

    de    = (h < H_ACT) && (v < V_ACT);
    hsync = (h >= HS_BEG) && (h < HS_END);
    vsync = (v >= VS_BEG) && (v < VS_END);

    // The origin pixel already uses the incoming mode, so the selection is
    // bypassed at (0,0) and the same value is what mode_q captures there.
    mode_eff = at_origin ? pattern_e'(mode) : mode_q;

    pixel = '0;
    if (de) begin
      unique case (mode_eff)
        PAT_HRAMP:   pixel = h[7:0];
        PAT_VRAMP:   pixel = v[7:0];
        PAT_CHECKER: pixel = (h[3] ^ v[3]) ? 8'hFF : 8'h00;
        PAT_BAR:     pixel = (((h[7:0] - frame_cnt) & 8'h3F) < 8'd8) ? 8'hFF : 8'h00;
        default:     pixel = '0;
      endcase
    end

    h_nxt = line_end ? '0 : h + 12'd1;
    v_nxt = v;
    if (line_end) begin
      v_nxt = (v == V_LAST) ? '0 : v + 12'd1;
    end

    frame_cnt_nxt = frame_end ? frame_cnt + 8'd1 : frame_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
      mode_q    <= PAT_HRAMP;
      out_image <= '0;
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
`ifdef PATTERN_GEN_SOF_EN
      out_sof   <= 1'b0;
`endif
    end else if (ce) begin
      h         <= h_nxt;
      v         <= v_nxt;
      frame_cnt <= frame_cnt_nxt;
      mode_q    <= mode_eff;
      out_image <= pixel;
      out_de    <= de;
      out_hsync <= hsync;
      out_vsync <= vsync;
`ifdef PATTERN_GEN_SOF_EN
      out_sof   <= at_origin;
`endif
    end
  end

endmodule
